// File: rtl/led_rgb_pwm_12bit.sv
// Three-channel LED PWM driver with a one-entry colour buffer that is applied only at period wrap.
// Optional LED_PWM_PHASE_STAGGER_EN offsets green/blue compare phases by 1/3 and 2/3 of a period.
module led_rgb_pwm_12bit #(
   parameter int unsigned COLOR_WIDTH_P = 12,
   parameter int unsigned PRESCALE_P    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_rgb,
   output logic                     ready,
   input  logic [COLOR_WIDTH_P-1:0] color_red,
   input  logic [COLOR_WIDTH_P-1:0] color_green,
   input  logic [COLOR_WIDTH_P-1:0] color_blue,
   output logic                     pwm_red,
   output logic                     pwm_green,
   output logic                     pwm_blue,
   output logic                     period_start
);

   localparam int unsigned W   = COLOR_WIDTH_P;
   localparam int unsigned PsW = (PRESCALE_P > 1) ? $clog2(PRESCALE_P) : 1;
   localparam logic [PsW-1:0] PsLast   = PsW'(PRESCALE_P - 1);
   localparam logic [W-1:0]   DutyFull = '1;
`ifdef LED_PWM_PHASE_STAGGER_EN
   localparam logic [W-1:0]   PhaseOfs = W'((2 ** W) / 3);
`else
   localparam logic [W-1:0]   PhaseOfs = '0;
`endif

   logic [PsW-1:0]      presc_q, presc_d;
   logic [W-1:0]        cnt_q, cnt_d;
   logic                run_q;
   logic                pend_valid_q;
   logic [2:0][W-1:0]   pend_q;
   logic [2:0][W-1:0]   act_q;
   logic [2:0][W-1:0]   phase;
   logic [2:0]          pwm_q, pwm_d;
   logic                period_start_q;
   logic                tick;
   logic                wrap;

   always_comb begin
      tick    = (presc_q == PsLast);
      wrap    = tick && (cnt_q == DutyFull);
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
      // run_q holds ready low until the first clock after reset is released
      ready   = run_q && !pend_valid_q;

      phase[0] = cnt_q;
      phase[1] = cnt_q + PhaseOfs;
      phase[2] = cnt_q + PhaseOfs + PhaseOfs;
      pwm_d    = '0;
      for (int unsigned c = 0; c < 3; c++) begin
         pwm_d[c] = (act_q[c] == DutyFull) || (phase[c] < act_q[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q        <= '0;
         cnt_q          <= '0;
         run_q          <= 1'b0;
         pend_valid_q   <= 1'b0;
         pend_q         <= '0;
         act_q          <= '0;
         pwm_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         run_q          <= 1'b1;
         pwm_q          <= pwm_d;
         period_start_q <= wrap;
         // Capture and update are exclusive: capture needs an empty buffer, update a full one,
         // so a colour taken in the wrap cycle waits for the following wrap.
         if (wrap && pend_valid_q) begin
            act_q        <= pend_q;
            pend_valid_q <= 1'b0;
         end else if (valid_rgb && ready) begin
            pend_q       <= {color_blue, color_green, color_red};
            pend_valid_q <= 1'b1;
         end
      end
   end

   assign pwm_red      = pwm_q[0];
   assign pwm_green    = pwm_q[1];
   assign pwm_blue     = pwm_q[2];
   assign period_start = period_start_q;

endmodule
